// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue sequencer feeding one ALU op at a time
// from a 4-entry register file, with preload, timeout and sticky error.
module alu_issue_ctrl #(
   parameter int DATA_SIZE     = 8,
   parameter int OP_CODE_SIZE  = 4,
   parameter int REG_ADDR_SIZE = 2
) (
   input  logic                                    CLOCK,
   input  logic                                    RESET,
   input  logic [OP_CODE_SIZE+3*REG_ADDR_SIZE-1:0] INSTR,
   input  logic                                    INSTR_VALID,
   output logic                                    INSTR_READY,
   input  logic                                    LOAD_EN,
   input  logic [REG_ADDR_SIZE-1:0]                LOAD_ADDR,
   input  logic [DATA_SIZE-1:0]                    LOAD_DATA,
   input  logic [REG_ADDR_SIZE-1:0]                RD_ADDR,
   output logic [DATA_SIZE-1:0]                    RD_DATA,
   output logic [DATA_SIZE-1:0]                    ALU_A,
   output logic [DATA_SIZE-1:0]                    ALU_B,
   output logic [OP_CODE_SIZE-1:0]                 ALU_OP,
   output logic                                    ALU_ENABLE,
   input  logic [DATA_SIZE-1:0]                    ALU_RESULT,
   input  logic                                    ALU_VALID,
   output logic                                    BUSY,
   output logic                                    DONE,
   output logic                                    ERROR
);

   localparam int RA   = REG_ADDR_SIZE;
   localparam int OPW  = OP_CODE_SIZE;
   localparam int NREG = 1 << RA;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t               state_q;
   logic [OPW-1:0]       op_q;
   logic [RA-1:0]        dst_q;
   logic [RA-1:0]        srca_q;
   logic [RA-1:0]        srcb_q;
   logic [DATA_SIZE-1:0] a_hold_q;
   logic [DATA_SIZE-1:0] b_hold_q;
   logic                 en_q;
   logic                 done_q;
   logic                 err_q;
   logic [1:0]           cnt_q;
   logic [DATA_SIZE-1:0] regs_q [NREG];

   logic [OPW-1:0]       in_op;
   logic [RA-1:0]        in_dst;
   logic [RA-1:0]        in_srca;
   logic [RA-1:0]        in_srcb;
   logic                 idle;
   logic                 accept;
   logic                 legal;
   logic                 wb;
   logic [DATA_SIZE-1:0] rd_a;
   logic [DATA_SIZE-1:0] rd_b;

   assign in_op   = INSTR[OPW+3*RA-1 -: OPW];
   assign in_dst  = INSTR[3*RA-1 -: RA];
   assign in_srca = INSTR[2*RA-1 -: RA];
   assign in_srcb = INSTR[RA-1:0];

   assign idle   = (state_q == S_IDLE);
   assign accept = INSTR_VALID & idle;
   assign legal  = ~in_op[OPW-1];
   assign wb     = (state_q == S_WAIT) & ALU_VALID;

   assign rd_a = regs_q[srca_q];
   assign rd_b = regs_q[srcb_q];

   // Operands come straight from the register file while issuing so a
   // preload on the accept edge is seen; afterwards the hold copy drives.
   assign ALU_A       = en_q ? rd_a : a_hold_q;
   assign ALU_B       = en_q ? rd_b : b_hold_q;
   assign ALU_OP      = op_q;
   assign ALU_ENABLE  = en_q;
   assign INSTR_READY = idle;
   assign BUSY        = ~idle;
   assign DONE        = done_q;
   assign ERROR       = err_q;
   assign RD_DATA     = regs_q[RD_ADDR];

   // Issue FSM with registered enable, done pulse, error and timeout.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         dst_q    <= '0;
         srca_q   <= '0;
         srcb_q   <= '0;
         a_hold_q <= '0;
         b_hold_q <= '0;
         en_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         en_q   <= 1'b0;
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (legal) begin
                     op_q    <= in_op;
                     dst_q   <= in_dst;
                     srca_q  <= in_srca;
                     srcb_q  <= in_srcb;
                     en_q    <= 1'b1;
                     state_q <= S_ISSUE;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               a_hold_q <= rd_a;
               b_hold_q <= rd_b;
               cnt_q    <= 2'd0;
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               if (ALU_VALID) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end else if (cnt_q == 2'd3) begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Register file: ALU writeback in WAIT, external preload only in IDLE.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (wb) begin
         regs_q[dst_q] <= ALU_RESULT;
      end else if (LOAD_EN && idle) begin
         regs_q[LOAD_ADDR] <= LOAD_DATA;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scenarios for alu_issue_ctrl; the bench
// plays the ALU, returning hand-computed results one cycle after issue.
module tb_alu_issue_ctrl;

   logic       CLOCK;
   logic       RESET;
   logic [9:0] INSTR;
   logic       INSTR_VALID;
   logic       INSTR_READY;
   logic       LOAD_EN;
   logic [1:0] LOAD_ADDR;
   logic [7:0] LOAD_DATA;
   logic [1:0] RD_ADDR;
   logic [7:0] RD_DATA;
   logic [7:0] ALU_A;
   logic [7:0] ALU_B;
   logic [3:0] ALU_OP;
   logic       ALU_ENABLE;
   logic [7:0] ALU_RESULT;
   logic       ALU_VALID;
   logic       BUSY;
   logic       DONE;
   logic       ERROR;

   int checks = 0;
   int failures = 0;

   alu_issue_ctrl dut (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .INSTR       (INSTR),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY),
      .LOAD_EN     (LOAD_EN),
      .LOAD_ADDR   (LOAD_ADDR),
      .LOAD_DATA   (LOAD_DATA),
      .RD_ADDR     (RD_ADDR),
      .RD_DATA     (RD_DATA),
      .ALU_A       (ALU_A),
      .ALU_B       (ALU_B),
      .ALU_OP      (ALU_OP),
      .ALU_ENABLE  (ALU_ENABLE),
      .ALU_RESULT  (ALU_RESULT),
      .ALU_VALID   (ALU_VALID),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .ERROR       (ERROR)
   );

   initial begin
      CLOCK = 1'b0;
      forever #5 CLOCK = ~CLOCK;
   end

   function automatic logic [9:0] mk(input logic [3:0] op,
                                     input logic [1:0] d,
                                     input logic [1:0] a,
                                     input logic [1:0] b);
      return {op, d, a, b};
   endfunction

   task automatic step();
      @(negedge CLOCK);
   endtask

   task automatic rd(input logic [1:0] a);
      RD_ADDR = a;
      #1;
   endtask

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      LOAD_EN   = 1'b1;
      LOAD_ADDR = a;
      LOAD_DATA = d;
      step();
      LOAD_EN = 1'b0;
   endtask

   task automatic do_reset();
      step();
      RESET = 1'b0;
      step();
      step();
      RESET = 1'b1;
   endtask

   task automatic test_reset();
      step();
      checks++; if (INSTR_READY !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", INSTR_READY); end
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
      checks++; if (ERROR !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", ERROR); end
      checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", DONE); end
      checks++; if (ALU_ENABLE !== 1'b0) begin failures++; $display("FAIL rst_en got=%b exp=0", ALU_ENABLE); end
      checks++; if ({ALU_A, ALU_B, ALU_OP} !== 20'h0) begin failures++; $display("FAIL rst_alu got=%h exp=0", {ALU_A, ALU_B, ALU_OP}); end
      for (int i = 0; i < 4; i++) begin
         rd(2'(i));
         checks++; if (RD_DATA !== 8'h00) begin failures++; $display("FAIL rst_reg%0d got=%h exp=00", i, RD_DATA); end
      end
      RESET = 1'b1;
   endtask

   task automatic test_add();
      load(2'd1, 8'h05);
      load(2'd2, 8'h03);
      rd(2'd1);
      checks++; if (RD_DATA !== 8'h05) begin failures++; $display("FAIL add_load got=%h exp=05", RD_DATA); end
      INSTR = mk(4'b0011, 2'd0, 2'd1, 2'd2);
      INSTR_VALID = 1'b1;
      step();
      INSTR_VALID = 1'b0;
      checks++; if (ALU_ENABLE !== 1'b1) begin failures++; $display("FAIL add_en got=%b exp=1", ALU_ENABLE); end
      checks++; if (ALU_A !== 8'h05) begin failures++; $display("FAIL add_a got=%h exp=05", ALU_A); end
      checks++; if (ALU_B !== 8'h03) begin failures++; $display("FAIL add_b got=%h exp=03", ALU_B); end
      checks++; if (ALU_OP !== 4'b0011) begin failures++; $display("FAIL add_op got=%b exp=0011", ALU_OP); end
      checks++; if (INSTR_READY !== 1'b0) begin failures++; $display("FAIL add_ready got=%b exp=0", INSTR_READY); end
      step();
      checks++; if (ALU_ENABLE !== 1'b0) begin failures++; $display("FAIL add_en_wait got=%b exp=0", ALU_ENABLE); end
      checks++; if (ALU_A !== 8'h05) begin failures++; $display("FAIL add_a_hold got=%h exp=05", ALU_A); end
      checks++; if (BUSY !== 1'b1 || DONE !== 1'b0) begin failures++; $display("FAIL add_wait got=%b%b exp=10", BUSY, DONE); end
      ALU_VALID  = 1'b1;
      ALU_RESULT = 8'h08;
      step();
      ALU_VALID = 1'b0;
      checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL add_done got=%b exp=1", DONE); end
      checks++; if (INSTR_READY !== 1'b1) begin failures++; $display("FAIL add_ready2 got=%b exp=1", INSTR_READY); end
      rd(2'd0);
      checks++; if (RD_DATA !== 8'h08) begin failures++; $display("FAIL add_r0 got=%h exp=08", RD_DATA); end
      step();
      checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL add_done_pulse got=%b exp=0", DONE); end
   endtask

   task automatic test_back_to_back();
      load(2'd1, 8'hF0);
      INSTR = mk(4'b0101, 2'd1, 2'd1, 2'd0);
      INSTR_VALID = 1'b1;
      step();
      checks++; if (ALU_A !== 8'hF0 || ALU_OP !== 4'b0101) begin failures++; $display("FAIL b2b_inv got=%h/%b exp=f0/0101", ALU_A, ALU_OP); end
      INSTR = mk(4'b0110, 2'd1, 2'd1, 2'd1);
      step();
      checks++; if (ALU_OP !== 4'b0101 || BUSY !== 1'b1) begin failures++; $display("FAIL b2b_noacc got=%b/%b exp=0101/1", ALU_OP, BUSY); end
      ALU_VALID  = 1'b1;
      ALU_RESULT = 8'h0F;
      step();
      ALU_VALID = 1'b0;
      rd(2'd1);
      checks++; if (RD_DATA !== 8'h0F || DONE !== 1'b1) begin failures++; $display("FAIL b2b_r1a got=%h/%b exp=0f/1", RD_DATA, DONE); end
      step();
      INSTR_VALID = 1'b0;
      checks++; if (ALU_ENABLE !== 1'b1 || ALU_OP !== 4'b0110) begin failures++; $display("FAIL b2b_xor_iss got=%b/%b exp=1/0110", ALU_ENABLE, ALU_OP); end
      checks++; if (ALU_A !== 8'h0F || ALU_B !== 8'h0F) begin failures++; $display("FAIL b2b_xor_ops got=%h/%h exp=0f/0f", ALU_A, ALU_B); end
      step();
      ALU_VALID  = 1'b1;
      ALU_RESULT = 8'h00;
      step();
      ALU_VALID = 1'b0;
      rd(2'd1);
      checks++; if (RD_DATA !== 8'h00 || DONE !== 1'b1) begin failures++; $display("FAIL b2b_r1b got=%h/%b exp=00/1", RD_DATA, DONE); end
   endtask

   task automatic test_illegal();
      INSTR = mk(4'b1000, 2'd0, 2'd0, 2'd0);
      INSTR_VALID = 1'b1;
      step();
      INSTR_VALID = 1'b0;
      checks++; if (ERROR !== 1'b1) begin failures++; $display("FAIL ill_err got=%b exp=1", ERROR); end
      checks++; if (ALU_ENABLE !== 1'b0) begin failures++; $display("FAIL ill_en got=%b exp=0", ALU_ENABLE); end
      checks++; if (INSTR_READY !== 1'b1 || BUSY !== 1'b0) begin failures++; $display("FAIL ill_idle got=%b%b exp=10", INSTR_READY, BUSY); end
      load(2'd2, 8'h0C);
      load(2'd3, 8'h03);
      INSTR = mk(4'b0010, 2'd0, 2'd2, 2'd3);
      INSTR_VALID = 1'b1;
      step();
      INSTR_VALID = 1'b0;
      checks++; if (ALU_A !== 8'h0C || ALU_B !== 8'h03) begin failures++; $display("FAIL ill_or_ops got=%h/%h exp=0c/03", ALU_A, ALU_B); end
      step();
      ALU_VALID  = 1'b1;
      ALU_RESULT = 8'h0F;
      step();
      ALU_VALID = 1'b0;
      rd(2'd0);
      checks++; if (RD_DATA !== 8'h0F || DONE !== 1'b1) begin failures++; $display("FAIL ill_or_r0 got=%h/%b exp=0f/1", RD_DATA, DONE); end
      checks++; if (ERROR !== 1'b1) begin failures++; $display("FAIL ill_sticky got=%b exp=1", ERROR); end
   endtask

   task automatic test_timeout();
      load(2'd2, 8'h55);
      INSTR = mk(4'b0011, 2'd2, 2'd0, 2'd0);
      INSTR_VALID = 1'b1;
      step();
      INSTR_VALID = 1'b0;
      checks++; if (ALU_ENABLE !== 1'b1) begin failures++; $display("FAIL to_en got=%b exp=1", ALU_ENABLE); end
      step();
      step();
      step();
      step();
      checks++; if (BUSY !== 1'b1 || ERROR !== 1'b0) begin failures++; $display("FAIL to_w4 got=%b%b exp=10", BUSY, ERROR); end
      step();
      checks++; if (BUSY !== 1'b0 || ERROR !== 1'b1) begin failures++; $display("FAIL to_exp got=%b%b exp=01", BUSY, ERROR); end
      checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL to_done got=%b exp=0", DONE); end
      rd(2'd2);
      checks++; if (RD_DATA !== 8'h55) begin failures++; $display("FAIL to_r2 got=%h exp=55", RD_DATA); end
      ALU_VALID  = 1'b1;
      ALU_RESULT = 8'hEE;
      step();
      ALU_VALID = 1'b0;
      rd(2'd2);
      checks++; if (RD_DATA !== 8'h55 || DONE !== 1'b0) begin failures++; $display("FAIL to_late got=%h/%b exp=55/0", RD_DATA, DONE); end
   endtask

   task automatic test_reset_mid();
      load(2'd1, 8'h11);
      INSTR = mk(4'b0011, 2'd0, 2'd1, 2'd1);
      INSTR_VALID = 1'b1;
      step();
      INSTR_VALID = 1'b0;
      step();
      RESET = 1'b0;
      rd(2'd1);
      checks++; if (RD_DATA !== 8'h00) begin failures++; $display("FAIL rm_r1 got=%h exp=00", RD_DATA); end
      checks++; if (BUSY !== 1'b0 || ALU_A !== 8'h00) begin failures++; $display("FAIL rm_async got=%b/%h exp=0/00", BUSY, ALU_A); end
      step();
      RESET      = 1'b1;
      ALU_VALID  = 1'b1;
      ALU_RESULT = 8'h77;
      #1;
      checks++; if (INSTR_READY !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", INSTR_READY); end
      step();
      ALU_VALID = 1'b0;
      rd(2'd0);
      checks++; if (RD_DATA !== 8'h00 || DONE !== 1'b0) begin failures++; $display("FAIL rm_nowb got=%h/%b exp=00/0", RD_DATA, DONE); end
   endtask

   task automatic test_load_gate();
      INSTR = mk(4'b0011, 2'd0, 2'd0, 2'd0);
      INSTR_VALID = 1'b1;
      step();
      INSTR_VALID = 1'b0;
      step();
      LOAD_EN    = 1'b1;
      LOAD_ADDR  = 2'd3;
      LOAD_DATA  = 8'hAA;
      ALU_VALID  = 1'b1;
      ALU_RESULT = 8'h12;
      step();
      LOAD_EN   = 1'b0;
      ALU_VALID = 1'b0;
      rd(2'd3);
      checks++; if (RD_DATA !== 8'h00) begin failures++; $display("FAIL ld_wait_r3 got=%h exp=00", RD_DATA); end
      rd(2'd0);
      checks++; if (RD_DATA !== 8'h12) begin failures++; $display("FAIL ld_wait_r0 got=%h exp=12", RD_DATA); end
      LOAD_EN     = 1'b1;
      INSTR       = mk(4'b0001, 2'd0, 2'd3, 2'd3);
      INSTR_VALID = 1'b1;
      step();
      LOAD_EN     = 1'b0;
      INSTR_VALID = 1'b0;
      checks++; if (ALU_A !== 8'hAA || ALU_B !== 8'hAA) begin failures++; $display("FAIL ld_same_ops got=%h/%h exp=aa/aa", ALU_A, ALU_B); end
      step();
      ALU_VALID  = 1'b1;
      ALU_RESULT = 8'h00;
      step();
      ALU_VALID = 1'b0;
      rd(2'd0);
      checks++; if (RD_DATA !== 8'h00 || DONE !== 1'b1) begin failures++; $display("FAIL ld_sub_r0 got=%h/%b exp=00/1", RD_DATA, DONE); end
      rd(2'd3);
      checks++; if (RD_DATA !== 8'hAA) begin failures++; $display("FAIL ld_sub_r3 got=%h exp=aa", RD_DATA); end
   endtask

   initial begin
      RESET       = 1'b0;
      INSTR       = '0;
      INSTR_VALID = 1'b0;
      LOAD_EN     = 1'b0;
      LOAD_ADDR   = '0;
      LOAD_DATA   = '0;
      RD_ADDR     = '0;
      ALU_RESULT  = '0;
      ALU_VALID   = 1'b0;
      test_reset();
      test_add();
      test_back_to_back();
      do_reset();
      test_illegal();
      do_reset();
      test_timeout();
      do_reset();
      test_reset_mid();
      do_reset();
      test_load_gate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter DATA_SIZE, default 8, operand/result width.
REQ-002 Parameter OP_CODE_SIZE, default 4, ALU opcode width.
REQ-003 Parameter REG_ADDR_SIZE, default 2, register-file index width (4 entries).
REQ-004 CLOCK  input  1  single clock; all state changes on rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 INSTR  input  OP_CODE_SIZE+3*REG_ADDR_SIZE  {OP, DST, SRCA, SRCB}, MSB first.
REQ-007 INSTR_VALID  input  1  INSTR is valid.
REQ-008 INSTR_READY  output  1  block can accept an instruction.
REQ-009 LOAD_EN / LOAD_ADDR / LOAD_DATA  input  1 / REG_ADDR_SIZE / DATA_SIZE  external register preload.
REQ-010 RD_ADDR  input  REG_ADDR_SIZE; RD_DATA  output  DATA_SIZE  combinational register read.
REQ-011 ALU_A, ALU_B  output  DATA_SIZE  operands to ALU.
REQ-012 ALU_OP  output  OP_CODE_SIZE  opcode to ALU.
REQ-013 ALU_ENABLE  output  1  ALU inputs valid.
REQ-014 ALU_RESULT  input  DATA_SIZE; ALU_VALID  input  1  result from ALU (one-cycle registered latency).
REQ-015 BUSY  output  1  state is not IDLE.
REQ-016 DONE  output  1  one-cycle pulse on writeback.
REQ-017 ERROR  output  1  sticky fault flag.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-019 INSTR_READY SHALL be 1 exactly when state is IDLE; accept = INSTR_VALID & INSTR_READY.
REQ-020 On accept with OP[MSB]=0: latch OP/DST/SRCA/SRCB, go to ISSUE.
REQ-021 On accept with OP[MSB]=1 (illegal): set ERROR, discard instruction, remain IDLE; no ALU_ENABLE.
REQ-022 ISSUE lasts exactly one cycle: ALU_ENABLE=1, ALU_OP=latched OP, ALU_A=REG[SRCA], ALU_B=REG[SRCB] (combinational from register file); next state WAIT.
REQ-023 ALU_ENABLE SHALL be 0 in every state other than ISSUE; ALU_A/ALU_B/ALU_OP hold last driven values outside ISSUE.
REQ-024 WAIT: on ALU_VALID=1, write ALU_RESULT to REG[DST] at that edge, pulse DONE for the following cycle, go IDLE.
REQ-025 WAIT timeout: 2-bit counter cleared on entry; if ALU_VALID not seen in 4 WAIT cycles, set ERROR, no write, go IDLE.
REQ-026 Nominal latency: accept edge N, ALU samples at N+1, writeback at N+2, INSTR_READY=1 again in cycle after N+2; max one instruction per 3 cycles.
REQ-027 LOAD_EN SHALL write LOAD_DATA to REG[LOAD_ADDR] only while state is IDLE; ignored otherwise.
REQ-028 LOAD_EN and accept in the same cycle: both occur; the loaded value is visible to that instruction in ISSUE.
REQ-029 SRCA=SRCB, or DST equal to a source, SHALL be legal; sources read pre-writeback values.
REQ-030 ALU_VALID while in IDLE or ISSUE SHALL be ignored.
REQ-031 RD_DATA SHALL reflect REG[RD_ADDR] combinationally, including the same-cycle-updated value after an edge.
REQ-032 ERROR, once set, SHALL persist until reset; it SHALL NOT block further instructions.

Reset
REQ-033 RESET=0 SHALL immediately, independent of CLOCK: state=IDLE, all registers=0, ALU_A=ALU_B=0, ALU_OP=0, ALU_ENABLE=0, DONE=0, ERROR=0, timeout counter=0.
REQ-034 Reset asserted in ISSUE or WAIT SHALL abort the operation with no writeback; an ALU_VALID arriving after release SHALL be ignored.
REQ-035 After RESET deasserts, INSTR_READY=1 on the first cycle.

Verification
REQ-036 Load R1=0x05, R2=0x03; issue ADD(0011) DST=R0 -> ALU_ENABLE one cycle with A=0x05 B=0x03, DONE two edges after accept, R0=0x08.
REQ-037 R1=0xF0; issue INV-A(0101) DST=R1 SRCA=R1 -> R1=0x0F; next back-to-back XOR R1,R1 -> R1=0x00, accepted only when INSTR_READY returns.
REQ-038 Issue opcode 1000 -> ERROR=1, no ALU_ENABLE, INSTR_READY stays 1; subsequent OR R0=0x0C|0x03 completes with 0x0F, ERROR still 1.
REQ-039 Hold ALU_VALID=0 after ISSUE -> after 4 WAIT cycles ERROR=1, BUSY=0, destination register unchanged.
REQ-040 Assert RESET=0 mid-WAIT, then ALU_VALID=1 after release -> all registers 0, no DONE, no write.
REQ-041 LOAD_EN during WAIT to R3=0xAA -> R3 unchanged; same load in IDLE concurrent with accept SUBB R0=R3-R3 -> R0=0x00, R3=0xAA.
